// File: rtl/spike_delay_pkg.sv
// spike_delay_pkg: shared types and helpers for the spike delay controller.
// Holds the FSM state encoding and the delay range helpers.
package spike_delay_pkg;

    typedef enum logic [1:0] {
        LOAD,
        FILL,
        RUN
    } state_t;

    // Shortest delay the RAM read pipeline can honour.
    function automatic int unsigned dmin(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    // Pull a requested delay into [lo, hi].
    function automatic int unsigned clamp_delay(
        input int unsigned d,
        input int unsigned lo,
        input int unsigned hi
    );
        if (d < lo) return lo;
        if (d > hi) return hi;
        return d;
    endfunction

endpackage

// File: rtl/spike_delay_ctrl_mod_counter.sv
// mod_counter: modulo-N up counter with enable and synchronous clear.
// Wraps from N-1 to 0 by explicit compare, so N need not be a power of two.
module mod_counter #(
    parameter int N     = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    // Count with clear taking priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/spike_delay_ctrl.sv
// spike_delay_ctrl: address sequencer and output gate for a circular spike delay RAM.
// Define SPIKE_DELAY_STATS_EN to build the saturating in/out spike counters.
module spike_delay_ctrl
    import spike_delay_pkg::*;
#(
    parameter int  DEPTH     = 1600000,
    parameter int  W         = 1,
    parameter int  RD_LAT    = 1,
    parameter int  DEF_DELAY = 1599995,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic [W-1:0]  spike_in,
    input  logic [AW:0]   delay_in,
    input  logic          delay_load,
    output logic          delay_ready,
    output logic          delay_err,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [W-1:0]  ram_dina,
    output logic [AW-1:0] ram_addrb,
    input  logic [W-1:0]  ram_doutb,
    output logic [W-1:0]  spike_out,
    output logic          out_valid,
    output logic [15:0]   in_count,
    output logic [15:0]   out_count
);
    localparam int unsigned   DLO      = dmin(RD_LAT);
    localparam int unsigned   DHI      = DEPTH;
    localparam logic [AW:0]   DEF_RAW  = (AW+1)'(DEF_DELAY);
    localparam logic [AW:0]   DEF_CL   = (AW+1)'(clamp_delay(DEF_DELAY, DLO, DHI));
    localparam logic [AW:0]   LAT_1    = (AW+1)'(RD_LAT + 1);
    localparam logic [AW-1:0] DEPTH_LO = AW'(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wa;
    logic [AW-1:0] fill_cnt;
    logic [AW:0]   req;
    logic [AW:0]   dly;
    logic [AW:0]   off;
    logic [AW:0]   dly_cl;
    logic [AW:0]   diff;
    logic [AW-1:0] rd_nx;
    logic          accept;
    logic          fill_en;
    logic          fill_clr;

    assign accept    = delay_ready & delay_load;
    assign dly_cl    = (AW+1)'(clamp_delay(32'(req), DLO, DHI));
    assign diff      = {1'b0, wa} - off;
    assign rd_nx     = diff[AW] ? diff[AW-1:0] + DEPTH_LO : diff[AW-1:0];
    assign ram_addra = wa;
    assign spike_out = out_valid ? ram_doutb : '0;

    mod_counter #(.N(DEPTH), .WIDTH(AW)) u_wa (
        .clk   (clk1),
        .rst   (reset),
        .clr   (1'b0),
        .en    (1'b1),
        .count (wa)
    );

    mod_counter #(.N(DEPTH), .WIDTH(AW)) u_fill (
        .clk   (clk1),
        .rst   (reset),
        .clr   (fill_clr),
        .en    (fill_en),
        .count (fill_cnt)
    );

    // State register.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // Next state and per-state controls; an accepted load always wins.
    always_comb begin
        state_nx    = state;
        delay_ready = 1'b0;
        out_valid   = 1'b0;
        fill_en     = 1'b0;
        fill_clr    = 1'b0;
        unique case (state)
            LOAD: begin
                state_nx = FILL;
                fill_clr = 1'b1;
            end
            FILL: begin
                delay_ready = 1'b1;
                fill_en     = 1'b1;
                if ({1'b0, fill_cnt} == dly - 1'b1) state_nx = RUN;
            end
            RUN: begin
                delay_ready = 1'b1;
                out_valid   = 1'b1;
            end
            default: state_nx = LOAD;
        endcase
        if (delay_ready && delay_load) state_nx = LOAD;
    end

    // Capture the request on accept; commit clamped delay and read offset in LOAD.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            req       <= DEF_RAW;
            dly       <= DEF_CL;
            off       <= '0;
            delay_err <= 1'b0;
        end else begin
            if (accept) req <= delay_in;
            if (state == LOAD) begin
                dly       <= dly_cl;
                off       <= dly_cl - LAT_1;
                delay_err <= (dly_cl != req);
            end
        end
    end

    // RAM port registers: write data lags spike_in by one cycle, read address trails wa.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ram_wea   <= 1'b0;
            ram_dina  <= '0;
            ram_addrb <= '0;
        end else begin
            ram_wea   <= 1'b1;
            ram_dina  <= spike_in;
            ram_addrb <= rd_nx;
        end
    end

`ifdef SPIKE_DELAY_STATS_EN
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    // Saturating activity counters, restarted by each accepted load.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (accept) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (|spike_in && in_cnt != 16'hFFFF)   in_cnt  <= in_cnt + 1'b1;
            if (|spike_out && out_cnt != 16'hFFFF) out_cnt <= out_cnt + 1'b1;
        end
    end

    assign in_count  = in_cnt;
    assign out_count = out_cnt;
`else
    assign in_count  = '0;
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_spike_delay_ctrl.sv
// tb_spike_delay_ctrl: directed bench for spike_delay_ctrl with DEPTH=16, D=8 default.
// Includes a read-first RAM model on the port pair.
module tb_spike_delay_ctrl;
    localparam int DEPTH     = 16;
    localparam int W         = 1;
    localparam int RD_LAT    = 1;
    localparam int DEF_DELAY = 8;
    localparam int AW        = 4;

    logic          clk1 = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  spike_in = '0;
    logic [AW:0]   delay_in = '0;
    logic          delay_load = 1'b0;
    logic          delay_ready;
    logic          delay_err;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [W-1:0]  ram_dina;
    logic [AW-1:0] ram_addrb;
    logic [W-1:0]  ram_doutb = '0;
    logic [W-1:0]  spike_out;
    logic          out_valid;
    logic [15:0]   in_count;
    logic [15:0]   out_count;

    logic [W-1:0] mem [DEPTH];
    int   total = 0;
    int   bad = 0;
    int   t, d, vfrom, in_m, out_m;
    logic hist [0:1023];
    logic err_m, pend_e, in_load;

    always #5 clk1 = ~clk1;

    spike_delay_ctrl #(
        .DEPTH(DEPTH), .W(W), .RD_LAT(RD_LAT), .DEF_DELAY(DEF_DELAY)
    ) dut (
        .clk1(clk1), .reset(reset), .spike_in(spike_in),
        .delay_in(delay_in), .delay_load(delay_load),
        .delay_ready(delay_ready), .delay_err(delay_err),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .spike_out(spike_out), .out_valid(out_valid),
        .in_count(in_count), .out_count(out_count)
    );

    // Read-first dual-port RAM, one cycle read latency.
    always @(posedge clk1) begin
        ram_doutb <= mem[ram_addrb];
        if (ram_wea) mem[ram_addra] <= ram_dina;
    end

    function automatic logic exp_out(input int tt);
        if (tt >= vfrom && tt - d >= 0) return hist[tt - d];
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_cnt(input int m);
`ifdef SPIKE_DELAY_STATS_EN
        return 16'(m);
`else
        return (m < 0) ? 16'd1 : 16'd0;
`endif
    endfunction

    task automatic step(input logic s, input logic ld, input logic [AW:0] dv, input logic acc);
        logic load_now;
        spike_in   = s;
        delay_load = ld;
        delay_in   = dv;
        hist[t+1]  = s;
        if (acc) begin
            in_m  = 0;
            out_m = 0;
        end else begin
            if (s && in_m < 65535) in_m++;
            if (exp_out(t) && out_m < 65535) out_m++;
        end
        load_now = in_load;
        in_load  = acc;
        @(posedge clk1);
        #1;
        t++;
        if (load_now) err_m = pend_e;
        spike_in   = '0;
        delay_load = 1'b0;
    endtask

    task automatic model_reset();
        t = 0; d = DEF_DELAY; vfrom = DEF_DELAY + 1;
        in_m = 0; out_m = 0;
        err_m = 1'b0; pend_e = 1'b0; in_load = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; spike_in = '1; delay_load = 1'b1; delay_in = 5'd3;
        @(posedge clk1); @(posedge clk1); #1;
        total++; if (ram_wea !== 1'b0) begin bad++; $display("FAIL rst_wea got %0h want 0", ram_wea); end
        total++; if ({ram_addra, ram_addrb} !== '0) begin bad++; $display("FAIL rst_addr got %0h/%0h want 0", ram_addra, ram_addrb); end
        total++; if (ram_dina !== '0) begin bad++; $display("FAIL rst_dina got %0h want 0", ram_dina); end
        total++; if ({spike_out, out_valid} !== '0) begin bad++; $display("FAIL rst_out got %0h/%0h want 0", spike_out, out_valid); end
        total++; if ({delay_ready, delay_err} !== 2'b00) begin bad++; $display("FAIL rst_ctl got %0h/%0h want 0", delay_ready, delay_err); end
        total++; if ({in_count, out_count} !== 32'h0) begin bad++; $display("FAIL rst_cnt got %0h/%0h want 0", in_count, out_count); end
        spike_in = '0; delay_load = 1'b0; delay_in = '0;
        @(negedge clk1);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_spike();
        int seen = 0, seen_t = -1, rise_t = -1;
        for (int i = 1; i <= 40; i++) begin
            step(i == 20, 1'b0, '0, 1'b0);
            if (out_valid === 1'b1 && rise_t < 0) rise_t = t;
            if (spike_out === 1'b1) begin seen++; seen_t = t; end
            total++; if (out_valid !== (t >= vfrom)) begin bad++; $display("FAIL single_valid t=%0d got %0h want %0h", t, out_valid, t >= vfrom); end
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL single_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (ram_addra !== AW'(t % DEPTH)) begin bad++; $display("FAIL single_addra t=%0d got %0d want %0d", t, ram_addra, t % DEPTH); end
            if (t >= 2) begin
                total++; if (ram_addrb !== AW'((t - 7 + DEPTH) % DEPTH)) begin bad++; $display("FAIL single_addrb t=%0d got %0d want %0d", t, ram_addrb, (t - 7 + DEPTH) % DEPTH); end
            end
            total++; if (ram_dina !== hist[t]) begin bad++; $display("FAIL single_dina t=%0d got %0h want %0h", t, ram_dina, hist[t]); end
            total++; if (ram_wea !== 1'b1) begin bad++; $display("FAIL single_wea t=%0d got %0h want 1", t, ram_wea); end
            total++; if (delay_ready !== !in_load) begin bad++; $display("FAIL single_ready t=%0d got %0h want %0h", t, delay_ready, !in_load); end
        end
        total++; if (rise_t !== 9) begin bad++; $display("FAIL single_rise got %0d want 9", rise_t); end
        total++; if (seen !== 1 || seen_t !== 28) begin bad++; $display("FAIL single_pulse got n=%0d t=%0d want n=1 t=28", seen, seen_t); end
        total++; if (in_count !== exp_cnt(1)) begin bad++; $display("FAIL single_in_cnt got %0d want %0d", in_count, exp_cnt(1)); end
        total++; if (out_count !== exp_cnt(1)) begin bad++; $display("FAIL single_out_cnt got %0d want %0d", out_count, exp_cnt(1)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step((i % 6 == 0) || (i % 6 == 2), 1'b0, '0, 1'b0);
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL b2b_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid t=%0d got %0h want 1", t, out_valid); end
        end
        total++; if (in_count !== exp_cnt(in_m)) begin bad++; $display("FAIL b2b_in_cnt got %0d want %0d", in_count, exp_cnt(in_m)); end
        total++; if (out_count !== exp_cnt(out_m)) begin bad++; $display("FAIL b2b_out_cnt got %0d want %0d", out_count, exp_cnt(out_m)); end
    endtask

    task automatic test_delay_bounds();
        int p, first;
        pend_e = 1'b0; step(1'b0, 1'b1, 5'd3, 1'b1); d = 3; p = t; vfrom = p + 4; first = -1;
        total++; if (delay_ready !== 1'b0) begin bad++; $display("FAIL dmin_ready got %0h want 0", delay_ready); end
        for (int i = 1; i <= 25; i++) begin
            step(i == 4 || i == 5 || i == 9, 1'b0, '0, 1'b0);
            if (spike_out === 1'b1 && first < 0) first = t;
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL dmin_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (out_valid !== (t >= vfrom)) begin bad++; $display("FAIL dmin_valid t=%0d got %0h want %0h", t, out_valid, t >= vfrom); end
            total++; if (delay_err !== 1'b0) begin bad++; $display("FAIL dmin_err t=%0d got %0h want 0", t, delay_err); end
        end
        total++; if (first !== p + 7) begin bad++; $display("FAIL dmin_lat got %0d want %0d", first, p + 7); end
        pend_e = 1'b0; step(1'b0, 1'b1, 5'd16, 1'b1); d = 16; p = t; vfrom = p + 17; first = -1;
        for (int i = 1; i <= 50; i++) begin
            step(i == 20 || i == 21 || i == 30, 1'b0, '0, 1'b0);
            if (spike_out === 1'b1 && first < 0) first = t;
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL dmax_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (out_valid !== (t >= vfrom)) begin bad++; $display("FAIL dmax_valid t=%0d got %0h want %0h", t, out_valid, t >= vfrom); end
            total++; if (delay_err !== 1'b0) begin bad++; $display("FAIL dmax_err t=%0d got %0h want 0", t, delay_err); end
        end
        total++; if (first !== p + 36) begin bad++; $display("FAIL dmax_lat got %0d want %0d", first, p + 36); end
    endtask

    task automatic test_clamp();
        int p, first;
        pend_e = 1'b1; step(1'b0, 1'b1, 5'd1, 1'b1); d = 3; p = t; vfrom = p + 4; first = -1;
        total++; if (delay_err !== 1'b0) begin bad++; $display("FAIL lo_err_early got %0h want 0", delay_err); end
        for (int i = 1; i <= 15; i++) begin
            step(i == 5, 1'b0, '0, 1'b0);
            if (spike_out === 1'b1 && first < 0) first = t;
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL lo_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (delay_err !== 1'b1) begin bad++; $display("FAIL lo_err t=%0d got %0h want 1", t, delay_err); end
        end
        total++; if (first !== p + 8) begin bad++; $display("FAIL lo_lat got %0d want %0d", first, p + 8); end
        pend_e = 1'b1; step(1'b0, 1'b1, 5'd31, 1'b1); d = 16; p = t; vfrom = p + 17; first = -1;
        for (int i = 1; i <= 40; i++) begin
            step(i == 3 || i == 10, 1'b0, '0, 1'b0);
            if (spike_out === 1'b1 && first < 0) first = t;
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL hi_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
            total++; if (delay_err !== 1'b1) begin bad++; $display("FAIL hi_err t=%0d got %0h want 1", t, delay_err); end
        end
        total++; if (first !== p + 19) begin bad++; $display("FAIL hi_lat got %0d want %0d", first, p + 19); end
        pend_e = 1'b0; step(1'b0, 1'b1, 5'd8, 1'b1); d = 8; vfrom = t + 9;
        total++; if (delay_err !== 1'b1) begin bad++; $display("FAIL clr_err_early got %0h want 1", delay_err); end
        for (int i = 1; i <= 20; i++) begin
            step(i == 2, 1'b0, '0, 1'b0);
            total++; if (delay_err !== 1'b0) begin bad++; $display("FAIL clr_err t=%0d got %0h want 0", t, delay_err); end
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL clr_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
        end
    endtask

    task automatic test_ignored_load();
        int p, rise_t = -1;
        pend_e = 1'b0; step(1'b0, 1'b1, 5'd6, 1'b1); d = 6; p = t; vfrom = p + 7;
        step(1'b0, 1'b1, 5'd3, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            step(i == 2, 1'b0, '0, 1'b0);
            if (out_valid === 1'b1 && rise_t < 0) rise_t = t;
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL ign_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
        end
        total++; if (rise_t !== p + 7) begin bad++; $display("FAIL ign_rise got %0d want %0d", rise_t, p + 7); end
    endtask

    task automatic test_reload_fill();
        int p, rise_t = -1, seen = 0, seen_t = -1;
        pend_e = 1'b0; step(1'b0, 1'b1, 5'd8, 1'b1); d = 8; vfrom = t + 9;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rl_fill_valid got %0h want 0", out_valid); end
        step(1'b0, 1'b1, 5'd5, 1'b1); d = 5; p = t; vfrom = p + 6;
        for (int i = 1; i <= 20; i++) begin
            step(i == 8, 1'b0, '0, 1'b0);
            if (out_valid === 1'b1 && rise_t < 0) rise_t = t;
            if (spike_out === 1'b1) begin seen++; seen_t = t; end
            total++; if (out_valid !== (t >= vfrom)) begin bad++; $display("FAIL rl_valid t=%0d got %0h want %0h", t, out_valid, t >= vfrom); end
        end
        total++; if (rise_t !== p + 6) begin bad++; $display("FAIL rl_rise got %0d want %0d", rise_t, p + 6); end
        total++; if (seen !== 1 || seen_t !== p + 13) begin bad++; $display("FAIL rl_pulse got n=%0d t=%0d want n=1 t=%0d", seen, seen_t, p + 13); end
        total++; if (in_count !== exp_cnt(1) || out_count !== exp_cnt(1)) begin bad++; $display("FAIL rl_cnt got %0d/%0d want %0d", in_count, out_count, exp_cnt(1)); end
    endtask

    task automatic test_reset_mid_run();
        int rise_t = -1, seen_t = -1;
        for (int i = 0; i < 10; i++) step(i % 3 == 0, 1'b0, '0, 1'b0);
        total++; if (in_count !== exp_cnt(in_m)) begin bad++; $display("FAIL pre_rst_cnt got %0d want %0d", in_count, exp_cnt(in_m)); end
        spike_in = '1; delay_load = 1'b1; delay_in = 5'd3;
        #3;
        reset = 1'b1;
        #1;
        total++; if ({ram_wea, ram_addra, ram_addrb, ram_dina} !== '0) begin bad++; $display("FAIL mid_rst_ram got %0h %0h %0h %0h want 0", ram_wea, ram_addra, ram_addrb, ram_dina); end
        total++; if ({spike_out, out_valid, delay_ready, delay_err} !== '0) begin bad++; $display("FAIL mid_rst_out got %0h %0h %0h %0h want 0", spike_out, out_valid, delay_ready, delay_err); end
        total++; if ({in_count, out_count} !== 32'h0) begin bad++; $display("FAIL mid_rst_cnt got %0h/%0h want 0", in_count, out_count); end
        spike_in = '0; delay_load = 1'b0; delay_in = '0;
        @(negedge clk1);
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 30; i++) begin
            step(i == 12, 1'b0, '0, 1'b0);
            if (out_valid === 1'b1 && rise_t < 0) rise_t = t;
            if (spike_out === 1'b1 && seen_t < 0) seen_t = t;
            total++; if (ram_addra !== AW'(t % DEPTH)) begin bad++; $display("FAIL post_addra t=%0d got %0d want %0d", t, ram_addra, t % DEPTH); end
            total++; if (spike_out !== exp_out(t)) begin bad++; $display("FAIL post_out t=%0d got %0h want %0h", t, spike_out, exp_out(t)); end
        end
        total++; if (rise_t !== 9) begin bad++; $display("FAIL post_rise got %0d want 9", rise_t); end
        total++; if (seen_t !== 20) begin bad++; $display("FAIL post_lat got %0d want 20", seen_t); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 1024; i++) hist[i] = 1'b0;
        model_reset();
        test_reset();
        test_single_spike();
        test_back_to_back();
        test_delay_bounds();
        test_clamp();
        test_ignored_load();
        test_reload_fill();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
